// File: rtl/adder_mb_pkg.sv
// Shared constants and FSM state type for the multi-byte add sequencer.
package adder_mb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_mb_seq.sv
// Multi-byte add sequencer: streams wide operands LSB-first through an external registered
// 8-bit adder, chaining carries. Define ADDER_MB_OVF_EN to add the two's-complement ovf output.
module adder_mb_seq
  import adder_mb_pkg::*;
#(
  parameter int NBYTES  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BYTE_W*NBYTES-1:0]   op_a,
  input  logic [BYTE_W*NBYTES-1:0]   op_b,
  input  logic                       cin_in,
  output logic                       busy,
  output logic                       done,
  output logic [BYTE_W*NBYTES-1:0]   result,
  output logic                       cout,
  output logic [BYTE_W-1:0]          add_a,
  output logic [BYTE_W-1:0]          add_b,
  output logic                       add_cin,
  input  logic [BYTE_W-1:0]          add_sum,
  input  logic                       add_carry
`ifdef ADDER_MB_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      opa_q, opa_d;
  logic [W-1:0]      opb_q, opb_d;
  logic [W-1:0]      result_q, result_d;
  logic              cout_q, cout_d;
  logic [BYTE_W-1:0] add_a_q, add_a_d;
  logic [BYTE_W-1:0] add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic              busy_q, done_q;
`ifdef ADDER_MB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  // Next-state logic: accept, issue one byte, wait out adder latency, capture and chain carry.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    cout_d    = cout_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
`ifdef ADDER_MB_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d     = op_a;
          opb_d     = op_b;
          result_d  = '0;
          cout_d    = 1'b0;
          add_a_d   = op_a[BYTE_W-1:0];
          add_b_d   = op_b[BYTE_W-1:0];
          add_cin_d = cin_in;
          k_d       = '0;
`ifdef ADDER_MB_OVF_EN
          ovf_d     = 1'b0;
`endif
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CW'(ADD_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          result_d[int'(k_q)*BYTE_W +: BYTE_W] = add_sum;
          if (k_q == KW'(NBYTES - 1)) begin
            cout_d  = add_carry;
`ifdef ADDER_MB_OVF_EN
            ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (add_sum[BYTE_W-1] != opa_q[W-1]);
`endif
            state_d = ST_DONE;
          end else begin
            k_d       = k_q + KW'(1);
            add_a_d   = opa_q[int'(k_d)*BYTE_W +: BYTE_W];
            add_b_d   = opb_q[int'(k_d)*BYTE_W +: BYTE_W];
            add_cin_d = add_carry;
            state_d   = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ADDER_MB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
`ifdef ADDER_MB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;
`ifdef ADDER_MB_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_adder_mb_seq.sv
// Directed self-checking bench for adder_mb_seq with a registered 8-bit adder model (latency 1).
module tb_adder_mb_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        cin_in;
  logic        busy, done, cout;
  logic [31:0] result;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_carry;
`ifdef ADDER_MB_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  adder_mb_seq #(.NBYTES(4), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry)
`ifdef ADDER_MB_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Registered ripple-carry adder model, one clock of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {add_carry, add_sum} <= 9'd0;
    else      {add_carry, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit repulse, output int lat, output int busy_low,
                        output logic cin_all);
    @(negedge clk);
    op_a = a; op_b = b; cin_in = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 0; busy_low = 0; cin_all = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_low++;
      cin_all = cin_all & add_cin;
      if (repulse && lat == 1) begin
        start = 1'b1; op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D; cin_in = 1'b1;
      end else if (repulse && lat == 2) begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  int   lat, busy_low, done_cnt, d_idx[3], nd;
  logic cin_all;

  initial begin
    rst = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0; cin_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, cout, result, add_a, add_b, add_cin}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, result}, 64'd0);

    // Carry across the byte 0/1 boundary, plus latency and handshake shape.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, busy_low, cin_all);
    chk("t1_latency", 64'(lat), 64'd8);
    chk("t1_result", {32'd0, result}, 64'h00000100);
    chk("t1_cout", {63'd0, cout}, 64'd0);
    chk("t1_busy_throughout", 64'(busy_low), 64'd0);
    chk("t1_busy_in_done", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("t1_done_one_cycle", {62'd0, done, busy}, 64'd0);

    // Full carry ripple, carry-in on every byte.
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, lat, busy_low, cin_all);
    chk("t2_result", {32'd0, result}, 64'h00000000);
    chk("t2_cout", {63'd0, cout}, 64'd1);
    chk("t2_add_cin_all_bytes", {63'd0, cin_all}, 64'd1);
    chk("t2_latency", 64'(lat), 64'd8);

    // Start re-pulse with changed operands while busy must be ignored.
    run_op(32'h12345678, 32'h87654321, 1'b0, 1'b1, lat, busy_low, cin_all);
    chk("t3_result", {32'd0, result}, 64'h99999999);
    chk("t3_cout", {63'd0, cout}, 64'd0);
    chk("t3_latency", 64'(lat), 64'd8);
    @(negedge clk);
    @(negedge clk);
    chk("t3_no_restart", {63'd0, busy}, 64'd0);

    // Reset asserted during WAIT of byte 2.
    @(negedge clk);
    op_a = 32'h11223344; op_b = 32'h55667788; cin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_mid_op_add_a", {56'd0, add_a}, 64'h22);
    chk("t4_partial_result", {32'd0, result}, 64'h0000AACC);
    rst = 1'b0;
    #1;
    chk("t4_rst_outputs", {busy, done, cout, result, add_a, add_b, add_cin}, 64'd0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("t4_no_done_no_busy", 64'(done_cnt), 64'd0);
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, lat, busy_low, cin_all);
    chk("t4_after_reset_result", {32'd0, result}, 64'h00000002);
    chk("t4_after_reset_latency", 64'(lat), 64'd8);

    // Back-to-back with start held high.
    @(negedge clk);
    @(negedge clk);
    op_a = 32'h01020304; op_b = 32'h10203040; cin_in = 1'b0; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 60 && nd < 3; i++) begin
      @(negedge clk);
      if (done) begin
        d_idx[nd] = i;
        nd++;
        chk("t5_result", {32'd0, result}, 64'h11223344);
      end
    end
    start = 1'b0;
    chk("t5_done_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("t5_gap1", 64'(d_idx[1] - d_idx[0] - 1), 64'd9);
      chk("t5_gap2", 64'(d_idx[2] - d_idx[1] - 1), 64'd9);
    end
    repeat (12) @(negedge clk);
    chk("t5_idle", {63'd0, busy}, 64'd0);

`ifdef ADDER_MB_OVF_EN
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, busy_low, cin_all);
    chk("ovf_pos_result", {32'd0, result}, 64'h80000000);
    chk("ovf_pos_flag", {63'd0, ovf}, 64'd1);
    chk("ovf_pos_cout", {63'd0, cout}, 64'd0);
    @(negedge clk);
    chk("ovf_holds", {63'd0, ovf}, 64'd1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, busy_low, cin_all);
    chk("ovf_neg_result", {32'd0, result}, 64'h00000000);
    chk("ovf_neg_flag", {63'd0, ovf}, 64'd0);
    chk("ovf_neg_cout", {63'd0, cout}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_mb_seq.md
Name: adder_mb_seq

Overview:
- Multi-byte add sequencer; sits directly upstream and downstream of the registered 8-bit ripple-carry adder (adder_pr).
- Latches two wide operands and issues them to the adder one byte at a time, LSB first.
- Captures each sum byte and feeds the returned carry back into the next byte's cin.
- Produces an NBYTES*8-bit result and a final carry, with a start/busy/done handshake.

Parameters:
- NBYTES, 4, number of 8-bit slices per operand (≥1).
- ADD_LAT, 1, adder clock edges from stable a/b/cin to valid sum/carry (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it low clears all state immediately.
- start  in  1  request; sampled only in IDLE.
- op_a  in  8*NBYTES  operand A, latched when start is accepted.
- op_b  in  8*NBYTES  operand B, latched when start is accepted.
- cin_in  in  1  carry into byte 0, latched when start is accepted.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result and cout are valid.
- result  out  8*NBYTES  sum; holds until the next accepted start.
- cout  out  1  carry out of the MSB byte.
- add_a  out  8  byte to adder a (registered).
- add_b  out  8  byte to adder b (registered).
- add_cin  out  1  carry to adder cin (registered).
- add_sum  in  8  adder sum.
- add_carry  in  1  adder carry.

Behaviour:
- Reset (rst=0): state IDLE. busy, done, result, cout, add_a, add_b, add_cin and the byte index are all 0. Latched operands are cleared.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 at an edge latches op_a, op_b and cin_in.
  - Clears result and cout.
  - Loads add_a=op_a[7:0], add_b=op_b[7:0], add_cin=cin_in.
  - Sets byte index k=0 and moves to ISSUE.
- ISSUE: lasts 1 cycle; the adder registers the byte. Moves to WAIT with wait counter = ADD_LAT-1.
- WAIT:
  - Lasts ADD_LAT cycles. Counter decrements each cycle; exit when counter = 0.
  - On the exit edge: result[8k+7:8k] <= add_sum.
  - If k < NBYTES-1: k <= k+1, add_a/add_b <= byte k+1, add_cin <= add_carry, go to ISSUE.
  - Otherwise: cout <= add_carry, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored during DONE.
- add_a, add_b and add_cin are stable from their load edge until the capture edge.
- Latency:
  - One byte takes 1+ADD_LAT cycles.
  - done is high in the cycle starting NBYTES*(1+ADD_LAT) edges after the start edge. Defaults: 8 cycles.
  - Earliest next accept: the first edge after done deasserts.
- start while busy (ISSUE, WAIT or DONE): ignored, no side effects.
- Arithmetic: {cout, result} = op_a + op_b + cin_in, modulo 2^(8*NBYTES+1). Carry propagates across byte boundaries only through add_carry.
- NBYTES=1: a single ISSUE/WAIT pass, then DONE.
- Reset mid-operation: immediate return to reset values. A partial result is discarded, done is not pulsed, and the next start behaves normally.

Optional Feature:
- Macro: ADDER_MB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered on the final capture edge.
  - ovf = (op_a MSB == op_b MSB) && (sum MSB != op_a MSB), i.e. two's-complement overflow.
  - ovf is cleared at reset and on start accept, and holds with result.
- Undefined: no ovf port and no associated logic.

Decomposition:
- Shared package adder_mb_pkg:
  - BYTE_W=8.
  - State enum typedef for IDLE, ISSUE, WAIT, DONE, 2-bit encoding.
- Byte-select mux and wait counter stay inline. No sub-module is warranted.
- The adder itself is instantiated by the parent and wired through the add_* ports.

Test Plan:
- NBYTES=4, ADD_LAT=1, bench instantiates the registered adder model.
- op_a=0x000000FF, op_b=0x00000001, cin_in=0 -> result 0x00000100, cout=0. done exactly 8 cycles after the start edge and high for one cycle; busy high throughout.
- op_a=0xFFFFFFFF, op_b=0x00000000, cin_in=1 -> result 0x00000000, cout=1. add_cin=1 observed for every byte.
- op_a=0x12345678, op_b=0x87654321, cin_in=0, with start re-pulsed and operands changed during WAIT -> result 0x99999999, cout=0. The second start has no effect.
- rst pulled low during WAIT of byte 2 -> busy, done, result, cout and add_* are 0 immediately with no done pulse. A new start with 0x00000001+0x00000001 -> result 0x00000002.
- Back-to-back: start held high continuously -> a new operation is accepted on the edge after done deasserts, and each done is separated by 9 cycles.
- With ADDER_MB_OVF_EN:
  - 0x7FFFFFFF+0x00000001 -> result 0x80000000, ovf=1, cout=0.
  - 0xFFFFFFFF+0x00000001 -> result 0, ovf=0, cout=1.
